// File: rtl/hilo_md_ctrl.sv
// hilo_md_ctrl: HI/LO register owner and multiply/divide sequencer for the EX stage.
// Issues divides to an external iterative divider and multiplies to an external
// pipelined multiplier, stalls EX until the result is captured, and handles
// MTHI/MTLO moves. The DONE state keeps a held instruction from being re-issued.
// Optional feature: define HILO_DIV0_BYPASS_EN to resolve divide-by-zero locally
// (hi=src1, lo=all ones) without starting the divider.
// MUL_LAT must lie in 1..7 (3-bit latency counter).
module hilo_md_ctrl #(
  parameter int MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  input  logic [2:0]  req_op,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  input  logic        flush,
  input  logic        ex_hold,
  output logic        div_start,
  output logic        div_signed,
  output logic        div_annul,
  output logic [31:0] div_opa,
  output logic [31:0] div_opb,
  input  logic [63:0] div_result,
  input  logic        div_ready,
  output logic        mul_signed,
  output logic [31:0] mul_ina,
  output logic [31:0] mul_inb,
  input  logic [63:0] mul_result,
  output logic        stallreq,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy
);

  localparam logic [2:0] OP_DIV   = 3'd0;
  localparam logic [2:0] OP_DIVU  = 3'd1;
  localparam logic [2:0] OP_MULT  = 3'd2;
  localparam logic [2:0] OP_MULTU = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
  localparam logic [2:0] MUL_LAT_C = 3'(MUL_LAT);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DIV_RUN = 2'd1,
    S_MUL_RUN = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] opa_q, opa_d;
  logic [31:0] opb_q, opb_d;
  logic        sgn_q, sgn_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        stall_c;

  // Request decode (only meaningful while IDLE)
  logic is_div, is_mul, is_mthi, is_mtlo, div_zero, div_issue;

  assign is_div  = req_valid && (req_op == OP_DIV  || req_op == OP_DIVU);
  assign is_mul  = req_valid && (req_op == OP_MULT || req_op == OP_MULTU);
  assign is_mthi = req_valid && (req_op == OP_MTHI);
  assign is_mtlo = req_valid && (req_op == OP_MTLO);

`ifdef HILO_DIV0_BYPASS_EN
  assign div_zero = is_div && (src2 == 32'd0);
`else
  assign div_zero = 1'b0;
`endif

  assign div_issue = is_div && !div_zero;

  // State and datapath registers; reset clears everything, divider keeps its own reset
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      opa_q   <= 32'd0;
      opb_q   <= 32'd0;
      sgn_q   <= 1'b0;
      cnt_q   <= 3'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      sgn_q   <= sgn_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Next-state: flush always returns to IDLE, otherwise follow the operation flow
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (div_issue)                          state_d = S_DIV_RUN;
          else if (is_mul)                        state_d = S_MUL_RUN;
          else if (is_mthi || is_mtlo || div_zero) state_d = S_DONE;
        end
        S_DIV_RUN: if (div_ready)       state_d = S_DONE;
        S_MUL_RUN: if (cnt_q == 3'd1)   state_d = S_DONE;
        S_DONE:    if (!ex_hold)        state_d = S_IDLE;
        default:                        state_d = S_IDLE;
      endcase
    end
  end

  // Datapath next values: operand latch, latency count, HI/LO writes (none on flush)
  always_comb begin
    opa_d = opa_q;
    opb_d = opb_q;
    sgn_d = sgn_q;
    cnt_d = cnt_q;
    hi_d  = hi_q;
    lo_d  = lo_q;
    if (!flush) begin
      case (state_q)
        S_IDLE: begin
          if (div_issue || is_mul) begin
            opa_d = src1;
            opb_d = src2;
            sgn_d = (req_op == OP_DIV) || (req_op == OP_MULT);
          end
          if (is_mul) cnt_d = MUL_LAT_C;
          if (is_mthi) hi_d = src1;
          if (is_mtlo) lo_d = src1;
          if (div_zero) begin
            hi_d = src1;
            lo_d = 32'hFFFF_FFFF;
          end
        end
        S_DIV_RUN: begin
          if (div_ready) begin
            hi_d = div_result[63:32];
            lo_d = div_result[31:0];
          end
        end
        S_MUL_RUN: begin
          cnt_d = 3'(cnt_q - 3'd1);
          if (cnt_q == 3'd1) begin
            hi_d = mul_result[63:32];
            lo_d = mul_result[31:0];
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs: operand buses are only live in their RUN state, stall drops on completion or flush
  always_comb begin
    stall_c    = 1'b0;
    busy       = 1'b0;
    div_start  = 1'b0;
    div_signed = 1'b0;
    div_annul  = 1'b0;
    div_opa    = 32'd0;
    div_opb    = 32'd0;
    mul_signed = 1'b0;
    mul_ina    = 32'd0;
    mul_inb    = 32'd0;
    case (state_q)
      S_IDLE: begin
        stall_c = !flush && (div_issue || is_mul);
      end
      S_DIV_RUN: begin
        busy       = 1'b1;
        div_start  = 1'b1;
        div_signed = sgn_q;
        div_opa    = opa_q;
        div_opb    = opb_q;
        div_annul  = flush;
        stall_c    = !flush && !div_ready;
      end
      S_MUL_RUN: begin
        busy       = 1'b1;
        mul_signed = sgn_q;
        mul_ina    = opa_q;
        mul_inb    = opb_q;
        stall_c    = !flush && (cnt_q != 3'd1);
      end
      default: ;
    endcase
  end

  // The issue-cycle stall is combinational from req_valid, so mask it while in reset
  assign stallreq = stall_c && resetn;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule
